console_poll_sequencer: RTL and testbench

- Sequences one controller-port shift register from the system clock domain.
- Synchronises the console's latch and clock pins and buffers MCU-supplied frames in a small FIFO.
- On each console latch, pops one frame and issues a one-cycle load strobe with that frame; on each console clock edge, issues a shift strobe.
- Counts shifted bits, flags overreads and counts lag frames (latch with no frame buffered).

---
 rtl/console_poll_pkg.sv | 16 +
 rtl/poll_frame_fifo.sv | 52 +++++
 rtl/console_poll_sequencer.sv | 150 +++++++++++++++
 tb/tb_console_poll_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/console_poll_pkg.sv
// Shared types and widths for the console poll sequencer.
package console_poll_pkg;

  typedef enum logic [2:0] {
    DISABLED,
    IDLE,
    LATCHED,
    SHIFTING,
    OVERREAD
  } poll_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int BIT_COUNT_W = 8;
  localparam int LAG_COUNT_W = 16;

endpackage

// File: rtl/poll_frame_fifo.sv
// Small synchronous frame FIFO: ready/valid push, pop on strobe, registered level.
module poll_frame_fifo #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign push_ready = (level != LW'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign head       = mem[rd_ptr];
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/console_poll_sequencer.sv
// Drives a controller-port shift register from console latch/clock pins:
// load strobe with a buffered frame on latch, shift strobe on each clock edge.
module console_poll_sequencer
  import console_poll_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] IDLE_FRAME = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         latch_in,
  input  logic                         con_clk_in,
  input  logic [WIDTH-1:0]             frame_data,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  output logic                         sr_load,
  output logic [WIDTH-1:0]             sr_frame,
  output logic                         sr_shift,
  output logic                         overread,
  output logic [BIT_COUNT_W-1:0]       bit_count,
  output logic [LAG_COUNT_W-1:0]       lag_count,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int PIN_LATCH = 0;
  localparam int PIN_CLK   = 1;

  // Per pin: [0],[1] synchroniser, [SYNC_STAGES] edge-detect flop.
  logic [1:0]                  pins;
  logic [1:0][SYNC_STAGES:0]   sync_q;
  logic [1:0]                  rise_q;
  logic                        lat_rise, clk_rise, lat_lvl;

  poll_state_t state_q, state_d;
  logic        load_ev, shift_ev, ovr_ev;
  logic [WIDTH-1:0] fifo_head;
  logic        fifo_empty;

  assign pins     = {con_clk_in, latch_in};
  assign lat_rise = rise_q[PIN_LATCH];
  assign clk_rise = rise_q[PIN_CLK];
  // Level taken from the edge flop so it lines up with the registered edge pulse.
  assign lat_lvl  = sync_q[PIN_LATCH][SYNC_STAGES];

  // Synchronise both pins and register a one-cycle rising-edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      rise_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        sync_q[p] <= {sync_q[p][SYNC_STAGES-1:0], pins[p]};
        rise_q[p] <= sync_q[p][SYNC_STAGES-1] & ~sync_q[p][SYNC_STAGES];
      end
    end
  end

  poll_frame_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_data  (frame_data),
    .push_valid (frame_valid),
    .push_ready (frame_ready),
    .pop        (load_ev),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= DISABLED;
    else     state_q <= state_d;
  end

  // Next state and strobe events; a latch edge always beats a clock edge.
  always_comb begin
    state_d  = state_q;
    load_ev  = 1'b0;
    shift_ev = 1'b0;
    ovr_ev   = 1'b0;
    if (!enable) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED: state_d = IDLE;
        IDLE: if (lat_rise) begin
          load_ev = 1'b1;
          state_d = LATCHED;
        end
        LATCHED: if (!lat_lvl) state_d = SHIFTING;
        SHIFTING: begin
          if (lat_rise) begin
            load_ev = 1'b1;
            state_d = LATCHED;
          end else if (clk_rise) begin
            shift_ev = 1'b1;
            if (bit_count >= BIT_COUNT_W'(WIDTH)) begin
              ovr_ev  = 1'b1;
              state_d = OVERREAD;
            end
          end
        end
        OVERREAD: begin
          if (lat_rise) begin
            load_ev = 1'b1;
            state_d = LATCHED;
          end else if (clk_rise) begin
            shift_ev = 1'b1;
            ovr_ev   = 1'b1;
          end
        end
        default: state_d = DISABLED;
      endcase
    end
  end

  // Registered strobes, presented frame and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_load   <= 1'b0;
      sr_shift  <= 1'b0;
      overread  <= 1'b0;
      sr_frame  <= IDLE_FRAME;
      bit_count <= '0;
      lag_count <= '0;
    end else begin
      sr_load  <= load_ev;
      sr_shift <= shift_ev;
      overread <= ovr_ev;
      if (load_ev) begin
        bit_count <= '0;
        if (fifo_empty) begin
          sr_frame <= IDLE_FRAME;
          if (lag_count != '1) lag_count <= lag_count + LAG_COUNT_W'(1);
        end else begin
          sr_frame <= fifo_head;
        end
      end else if (shift_ev && bit_count != '1) begin
        bit_count <= bit_count + BIT_COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_console_poll_sequencer.sv
// Directed bench with a frame scoreboard checked on every sr_load.
module tb_console_poll_sequencer;

  localparam int W  = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst, enable, latch_in, con_clk_in, frame_valid;
  logic [W-1:0]  frame_data;
  logic          frame_ready, sr_load, sr_shift, overread;
  logic [W-1:0]  sr_frame;
  logic [7:0]    bit_count;
  logic [15:0]   lag_count;
  logic [2:0]    fifo_level;

  int total = 0;
  int bad   = 0;

  // scoreboard / model
  logic [W-1:0] exp_q [$];
  logic [W-1:0] mq [$];
  int exp_lag = 0;
  int n_load = 0, n_shift = 0, n_ovr = 0, sh_idx = 0;
  int ovr_q [$];
  int l0, s0, o0;

  console_poll_sequencer #(.WIDTH(W), .FIFO_DEPTH(FD), .IDLE_FRAME(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .latch_in(latch_in), .con_clk_in(con_clk_in),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .sr_load(sr_load), .sr_frame(sr_frame), .sr_shift(sr_shift), .overread(overread),
    .bit_count(bit_count), .lag_count(lag_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pop the scoreboard on each load, tally shifts and overreads.
  always @(negedge clk) begin
    if (!rst) begin
      if (sr_load) begin
        if (exp_q.size() == 0) check("sb_unexpected_load", 1, 0);
        else check("sb_frame", sr_frame, exp_q.pop_front());
        n_load++;
        sh_idx = 0;
      end
      if (sr_shift) begin
        n_shift++;
        sh_idx++;
      end
      if (overread) begin
        check("ovr_with_shift", sr_shift, 1);
        n_ovr++;
        ovr_q.push_back(sh_idx);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [W-1:0] f);
    @(negedge clk);
    check("frame_ready_pre_push", frame_ready, mq.size() < FD);
    if (mq.size() < FD) mq.push_back(f);
    frame_data  = f;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic expect_load();
    if (mq.size() == 0) begin
      exp_q.push_back(16'hFFFF);
      exp_lag++;
    end else begin
      exp_q.push_back(mq.pop_front());
    end
  endtask

  task automatic latch_pulse(input int hi, input bit want_load);
    if (want_load) expect_load();
    @(negedge clk);
    latch_in = 1'b1;
    repeat (hi) @(negedge clk);
    latch_in = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic clk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      con_clk_in = 1'b1;
      repeat (4) @(negedge clk);
      con_clk_in = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_sr_load"},  sr_load, 0);
    check({pfx, "_sr_shift"}, sr_shift, 0);
    check({pfx, "_overread"}, overread, 0);
    check({pfx, "_sr_frame"}, sr_frame, 16'hFFFF);
    check({pfx, "_bit_count"}, bit_count, 0);
    check({pfx, "_lag_count"}, lag_count, 0);
    check({pfx, "_fifo_level"}, fifo_level, 0);
    check({pfx, "_frame_ready"}, frame_ready, 1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; latch_in = 1'b0; con_clk_in = 1'b0;
    frame_valid = 1'b0; frame_data = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // load and shift, with exact pin-to-strobe latency
    push(16'hA5C3);
    @(negedge clk);
    check("level_after_push", fifo_level, 1);
    expect_load();
    l0 = n_load; s0 = n_shift; o0 = n_ovr;
    latch_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("load_latency_early", sr_load, 0);
    @(posedge clk);
    #1 check("load_latency_on", sr_load, 1);
    repeat (3) @(negedge clk);
    latch_in = 1'b0;
    repeat (8) @(negedge clk);
    clk_pulses(16);
    check("t1_loads", n_load - l0, 1);
    check("t1_shifts", n_shift - s0, 16);
    check("t1_ovr", n_ovr - o0, 0);
    check("t1_bit_count", bit_count, 16);
    check("t1_lag", lag_count, 0);
    check("t1_frame_held", sr_frame, 16'hA5C3);
    check("t1_level", fifo_level, 0);

    // overread on shifts 17 and 18
    push(16'h3C5A);
    s0 = n_shift; o0 = n_ovr; ovr_q.delete();
    latch_pulse(6, 1);
    clk_pulses(18);
    check("t2_shifts", n_shift - s0, 18);
    check("t2_ovr", n_ovr - o0, 2);
    if (ovr_q.size() == 2) begin
      check("t2_ovr_first", ovr_q[0], 17);
      check("t2_ovr_second", ovr_q[1], 18);
    end else check("t2_ovr_list", ovr_q.size(), 2);
    check("t2_bit_count", bit_count, 18);

    // lag: three latches on an empty FIFO
    for (int i = 0; i < 3; i++) latch_pulse(6, 1);
    check("t3_lag", lag_count, exp_lag);
    check("t3_lag3", lag_count, 3);
    check("t3_level", fifo_level, 0);
    check("t3_frame", sr_frame, 16'hFFFF);

    // full FIFO: fifth push refused, order preserved
    for (int i = 1; i <= 5; i++) push(W'(i));
    @(negedge clk);
    check("t4_ready_full", frame_ready, 0);
    check("t4_level_full", fifo_level, 4);
    for (int i = 0; i < 4; i++) latch_pulse(6, 1);
    check("t4_ready_after", frame_ready, 1);
    check("t4_level_after", fifo_level, 0);
    check("t4_lag", lag_count, exp_lag);

    // latch priority: coincident clock edge, then clock toggling under latch
    l0 = n_load; s0 = n_shift;
    expect_load();
    @(negedge clk);
    latch_in = 1'b1; con_clk_in = 1'b1;
    repeat (4) @(negedge clk);
    con_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    con_clk_in = 1'b1;
    repeat (4) @(negedge clk);
    con_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    latch_in = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_loads", n_load - l0, 1);
    check("t5_no_shift", n_shift - s0, 0);
    check("t5_bit_count", bit_count, 0);

    // mid-frame reset after 5 shifts with a frame buffered
    clk_pulses(5);
    check("t5_bit_count5", bit_count, 5);
    push(16'h7777);
    @(negedge clk);
    check("t5_level_pre_rst", fifo_level, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); exp_q.delete(); exp_lag = 0;
    repeat (3) @(negedge clk);
    latch_pulse(6, 1);
    check("t5_post_rst_frame", sr_frame, 16'hFFFF);
    check("t5_post_rst_lag", lag_count, 1);

    // disable: no strobes, counters frozen, pushes still accepted
    clk_pulses(3);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    l0 = n_load; s0 = n_shift;
    latch_pulse(6, 0);
    clk_pulses(3);
    push(16'h1111);
    @(negedge clk);
    check("t6_level", fifo_level, 1);
    check("t6_loads", n_load - l0, 0);
    check("t6_shifts", n_shift - s0, 0);
    check("t6_bit_count", bit_count, 3);
    check("t6_lag", lag_count, 1);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    latch_pulse(6, 1);
    check("t6_reen_loads", n_load - l0, 1);
    check("t6_reen_frame", sr_frame, 16'h1111);
    check("t6_reen_level", fifo_level, 0);
    check("t6_reen_bit_count", bit_count, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
